// File: rtl/mips_multicycle_control_if.sv
// Control bundle between the multicycle MIPS control FSM and its datapath.
// master = control unit (drives controls), slave = datapath (drives Op/Funct).
interface mips_multicycle_control_if #(
    parameter int CNT_W = 16
);
    logic [5:0]       Op;
    logic [5:0]       Funct;
    logic             IorD;
    logic             MemWrite;
    logic             IRWrite;
    logic             PCWrite;
    logic             Branch;
    logic             PCSrc;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [2:0]       ALUControl;
    logic             RegWrite;
    logic             MemtoReg;
    logic             RegDst;
    logic [3:0]       State_o;
    logic             Illegal_o;
    logic [CNT_W-1:0] Retired_o;

    modport master (
        input  Op, Funct,
        output IorD, MemWrite, IRWrite, PCWrite, Branch, PCSrc, ALUSrcA, ALUSrcB,
               ALUControl, RegWrite, MemtoReg, RegDst, State_o, Illegal_o, Retired_o
    );

    modport slave (
        output Op, Funct,
        input  IorD, MemWrite, IRWrite, PCWrite, Branch, PCSrc, ALUSrcA, ALUSrcB,
               ALUControl, RegWrite, MemtoReg, RegDst, State_o, Illegal_o, Retired_o
    );
endinterface

// File: rtl/mips_multicycle_control.sv
// Moore control FSM + ALU decoder for the multicycle MIPS datapath, with retired-instruction counter.
// Latency: controls are decoded from the current state (EXEC ALU op also from Funct); 2..5 cycles per instruction.
// Backpressure: none; sequencing is fixed per opcode, reset aborts the instruction immediately.
module mips_multicycle_control #(
    parameter int CNT_W = 16
) (
    input logic                       clk,
    input logic                       rst,
    mips_multicycle_control_if.master bus
);
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] retired;
    logic             retire;

    logic       iord, mem_write, ir_write, pc_write, branch, pc_src, alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctl;
    logic       reg_write, mem_to_reg, reg_dst, illegal;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = FETCH;
        iord       = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        pc_src     = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_ctl    = 3'b000;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_dst    = 1'b0;
        illegal    = 1'b0;
        retire     = 1'b0;
        case (state)
            FETCH: begin
                iord      = 1'b1;
                ir_write  = 1'b1;
                alu_src_a = 1'b1;
                alu_src_b = 2'b01;
                pc_src    = 1'b1;
                pc_write  = 1'b1;
                state_nxt = DECODE;
            end
            DECODE: begin
                // Branch target is precomputed here so BRANCH only needs the compare.
                alu_src_a = 1'b1;
                alu_src_b = 2'b11;
                case (bus.Op)
                    OP_LW, OP_SW: state_nxt = MEMADR;
                    OP_R:         state_nxt = EXEC;
                    OP_BEQ:       state_nxt = BRANCH;
                    OP_ADDI:      state_nxt = ADDIEX;
                    default:      illegal   = 1'b1;
                endcase
            end
            MEMADR: begin
                alu_src_b = 2'b10;
                state_nxt = (bus.Op == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: state_nxt = MEMWB;
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
            end
            MEMWR: begin
                mem_write = 1'b1;
                retire    = 1'b1;
            end
            EXEC: begin
                state_nxt = ALUWB;
                case (bus.Funct)
                    6'b100000: alu_ctl = 3'b000;
                    6'b100010: alu_ctl = 3'b001;
                    6'b100100: alu_ctl = 3'b010;
                    6'b100101: alu_ctl = 3'b011;
                    6'b101010: alu_ctl = 3'b100;
                    default: begin
                        illegal   = 1'b1;
                        state_nxt = FETCH;
                    end
                endcase
            end
            ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                retire    = 1'b1;
            end
            BRANCH: begin
                alu_ctl = 3'b001;
                branch  = 1'b1;
                retire  = 1'b1;
            end
            ADDIEX: begin
                alu_src_b = 2'b10;
                state_nxt = ADDIWB;
            end
            ADDIWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            default: state_nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retired <= '0;
        end else if (retire) begin
            retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Reset state is FETCH, whose controls would write PC/IR; gate everything while reset is held.
    assign bus.IorD       = rst & iord;
    assign bus.MemWrite   = rst & mem_write;
    assign bus.IRWrite    = rst & ir_write;
    assign bus.PCWrite    = rst & pc_write;
    assign bus.Branch     = rst & branch;
    assign bus.PCSrc      = rst & pc_src;
    assign bus.ALUSrcA    = rst & alu_src_a;
    assign bus.ALUSrcB    = rst ? alu_src_b : 2'b00;
    assign bus.ALUControl = rst ? alu_ctl : 3'b000;
    assign bus.RegWrite   = rst & reg_write;
    assign bus.MemtoReg   = rst & mem_to_reg;
    assign bus.RegDst     = rst & reg_dst;
    assign bus.Illegal_o  = rst & illegal;
    assign bus.State_o    = state;
    assign bus.Retired_o  = retired;
endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control: directed cases then random instruction mix against a table model.
module tb_mips_multicycle_control;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    int   retired_cnt = 0;
    int   exp_seq[$];
    bit   exp_legal;

    always #5 clk = ~clk;

    mips_multicycle_control_if #(.CNT_W(16)) bus16 ();
    mips_multicycle_control_if #(.CNT_W(2))  bus2 ();

    mips_multicycle_control #(.CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus16.master));
    mips_multicycle_control #(.CNT_W(2))  dut2 (.clk(clk), .rst(rst), .bus(bus2.master));

    localparam logic [5:0] LEGAL_FN [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    function automatic bit funct_legal(logic [5:0] fn);
        foreach (LEGAL_FN[k]) if (LEGAL_FN[k] == fn) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit op_legal(logic [5:0] op);
        return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000};
    endfunction

    // Order: IorD MemWrite IRWrite PCWrite Branch PCSrc ALUSrcA ALUSrcB[2] ALUControl[3] RegWrite MemtoReg RegDst Illegal
    function automatic logic [16:0] exp_vec(int st, logic [5:0] op, logic [5:0] fn);
        logic [16:0] v = '0;
        case (st)
            0: v = {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 3'b000, 4'b0000};
            1: v = {7'b0000001, 2'b11, 3'b000, 3'b000, !op_legal(op)};
            2: v = {7'b0, 2'b10, 3'b000, 4'b0000};
            4: v = {7'b0, 2'b00, 3'b000, 4'b1100};
            5: v = {7'b0100000, 2'b00, 3'b000, 4'b0000};
            6: begin
                v[0] = !funct_legal(fn);
                case (fn)
                    6'b100010: v[6:4] = 3'b001;
                    6'b100100: v[6:4] = 3'b010;
                    6'b100101: v[6:4] = 3'b011;
                    6'b101010: v[6:4] = 3'b100;
                    default:   v[6:4] = 3'b000;
                endcase
            end
            7: v = {7'b0, 2'b00, 3'b000, 4'b1010};
            8: v = {7'b0000100, 2'b00, 3'b001, 4'b0000};
            9: v = {7'b0, 2'b10, 3'b000, 4'b0000};
            10: v = {7'b0, 2'b00, 3'b000, 4'b1000};
            default: v = '0;
        endcase
        return v;
    endfunction

    function automatic logic [16:0] obs16();
        return {bus16.IorD, bus16.MemWrite, bus16.IRWrite, bus16.PCWrite, bus16.Branch, bus16.PCSrc,
                bus16.ALUSrcA, bus16.ALUSrcB, bus16.ALUControl, bus16.RegWrite, bus16.MemtoReg,
                bus16.RegDst, bus16.Illegal_o};
    endfunction

    function automatic logic [16:0] obs2();
        return {bus2.IorD, bus2.MemWrite, bus2.IRWrite, bus2.PCWrite, bus2.Branch, bus2.PCSrc,
                bus2.ALUSrcA, bus2.ALUSrcB, bus2.ALUControl, bus2.RegWrite, bus2.MemtoReg,
                bus2.RegDst, bus2.Illegal_o};
    endfunction

    task automatic chk(string tag, logic [31:0] observed, logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // State walk per instruction class, straight from the cycle table.
    task automatic build_seq(logic [5:0] op, logic [5:0] fn);
        exp_seq.delete();
        exp_legal = 1'b1;
        case (op)
            6'b100011: exp_seq = '{0, 1, 2, 3, 4};
            6'b101011: exp_seq = '{0, 1, 2, 5};
            6'b000000: if (funct_legal(fn)) exp_seq = '{0, 1, 6, 7};
                       else begin exp_seq = '{0, 1, 6}; exp_legal = 1'b0; end
            6'b000100: exp_seq = '{0, 1, 8};
            6'b001000: exp_seq = '{0, 1, 9, 10};
            default:   begin exp_seq = '{0, 1}; exp_legal = 1'b0; end
        endcase
    endtask

    task automatic drive(logic [5:0] op, logic [5:0] fn);
        bus16.Op = op; bus16.Funct = fn;
        bus2.Op  = op; bus2.Funct  = fn;
    endtask

    // Called at a sample point inside FETCH; returns sampling the next FETCH (or the abort state).
    task automatic run_instr(logic [5:0] op, logic [5:0] fn, int abort_at);
        drive(op, fn);
        build_seq(op, fn);
        #1;
        chk("retired16", 32'(bus16.Retired_o), 32'(retired_cnt % 65536));
        chk("retired2", 32'(bus2.Retired_o), 32'(retired_cnt % 4));
        foreach (exp_seq[i]) begin
            chk($sformatf("state op=%b fn=%b step%0d", op, fn, i), 32'(bus16.State_o), 32'(exp_seq[i]));
            chk($sformatf("ctl op=%b fn=%b st%0d", op, fn, exp_seq[i]), 32'(obs16()),
                32'(exp_vec(exp_seq[i], op, fn)));
            chk("ctl_w2", 32'(obs2()), 32'(exp_vec(exp_seq[i], op, fn)));
            if (i == abort_at) return;
            @(negedge clk);
            #1;
        end
        if (exp_legal) retired_cnt++;
    endtask

    initial begin
        logic [5:0] op;
        logic [5:0] fn;
        drive(6'b000000, 6'b000000);
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("reset_ctl", 32'(obs16()), 32'd0);
            chk("reset_state", 32'(bus16.State_o), 32'd0);
            chk("reset_retired", 32'(bus16.Retired_o), 32'd0);
        end
        rst = 1'b1;
        #1;
        chk("post_reset_ctl", 32'(obs16()), 32'(exp_vec(0, 6'b0, 6'b0)));

        run_instr(6'b100011, 6'b000000, -1);
        run_instr(6'b101011, 6'b000000, -1);
        run_instr(6'b000000, 6'b100010, -1);
        run_instr(6'b000000, 6'b101010, -1);
        run_instr(6'b000100, 6'b000000, -1);
        run_instr(6'b111111, 6'b000000, -1);
        run_instr(6'b000000, 6'b111111, -1);
        run_instr(6'b001000, 6'b000000, -1);

        // Abort an lw in MEMRD: state and counter clear at once, no writeback follows.
        run_instr(6'b100011, 6'b000000, 3);
        rst = 1'b0;
        #1;
        chk("abort_state", 32'(bus16.State_o), 32'd0);
        chk("abort_retired16", 32'(bus16.Retired_o), 32'd0);
        chk("abort_retired2", 32'(bus2.Retired_o), 32'd0);
        chk("abort_ctl", 32'(obs16()), 32'd0);
        @(negedge clk);
        #1;
        chk("abort_hold_ctl", 32'(obs16()), 32'd0);
        rst = 1'b1;
        retired_cnt = 0;

        repeat (5) run_instr(6'b001000, 6'b000000, -1);

        for (int n = 0; n < 300; n++) begin
            fn = 6'($urandom_range(0, 63));
            case ($urandom_range(0, 9))
                0, 1: op = 6'b100011;
                2: op = 6'b101011;
                3, 4: begin op = 6'b000000; fn = LEGAL_FN[$urandom_range(0, 4)]; end
                5: op = 6'b000000;
                6: op = 6'b000100;
                7: op = 6'b001000;
                8: begin
                    op = 6'($urandom_range(0, 63));
                    while (op_legal(op)) op = 6'($urandom_range(0, 63));
                end
                default: op = 6'($urandom_range(0, 63));
            endcase
            run_instr(op, fn, -1);
        end
        #1;
        chk("final_retired16", 32'(bus16.Retired_o), 32'(retired_cnt % 65536));
        chk("final_retired2", 32'(bus2.Retired_o), 32'(retired_cnt % 4));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
